// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: coordinates, blanking flags and sync pulses for one pixel per clock.
interface vga_timing_gen_if;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        frame_start_out;

  modport master (
    output hcount_out, vcount_out, hblnk_out, vblnk_out,
           hsync_out, vsync_out, frame_start_out
  );

  modport slave (
    input hcount_out, vcount_out, hblnk_out, vblnk_out,
          hsync_out, vsync_out, frame_start_out
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator. Counters and every flag are registered together from
// the next-state values, so a flag always describes the coordinate shown in the same cycle.
// Syncs are active-high here; polarity inversion is left to the top-level pins.
// H_SYNC and V_SYNC must be non-zero; H_TOTAL <= 2048 and V_TOTAL <= 1024.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 1024,
  parameter int unsigned H_FP      = 24,
  parameter int unsigned H_SYNC    = 136,
  parameter int unsigned H_BP      = 160,
  parameter int unsigned V_VISIBLE = 768,
  parameter int unsigned V_FP      = 3,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BP      = 29
) (
  input  logic               clk,
  input  logic               rst,
  vga_timing_gen_if.master   vga
);

  localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HLast = 11'(HTotal - 1);
  localparam logic [9:0]  VLast = 10'(VTotal - 1);

  // Decode bounds one bit wider than the counters so a sync pulse ending exactly at the
  // maximum total (2048 / 1024) does not wrap to zero.
  localparam logic [11:0] HVis       = 12'(H_VISIBLE);
  localparam logic [11:0] HSyncStart = 12'(H_VISIBLE + H_FP);
  localparam logic [11:0] HSyncEnd   = 12'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VVis       = 11'(V_VISIBLE);
  localparam logic [10:0] VSyncStart = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VSyncEnd   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d;
  logic        h_wrap;
  logic [11:0] h_ext;
  logic [10:0] v_ext;

  // Next position and the flags decoded from that next position.
  always_comb begin
    h_wrap   = (hcount_q == HLast);
    hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = (vcount_q == VLast) ? 10'd0 : vcount_q + 10'd1;
    end
    h_ext         = {1'b0, hcount_d};
    v_ext         = {1'b0, vcount_d};
    hblnk_d       = (h_ext >= HVis);
    vblnk_d       = (v_ext >= VVis);
    hsync_d       = (h_ext >= HSyncStart) && (h_ext < HSyncEnd);
    vsync_d       = (v_ext >= VSyncStart) && (v_ext < VSyncEnd);
    frame_start_d = (hcount_d == 11'd0) && (vcount_d == 10'd0);
  end

  // Position and flag registers; reset parks everything at (0,0) with all flags low.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Drive the bundle straight from the registers.
  always_comb begin
    vga.hcount_out      = hcount_q;
    vga.vcount_out      = vcount_q;
    vga.hblnk_out       = hblnk_q;
    vga.vblnk_out       = vblnk_q;
    vga.hsync_out       = hsync_q;
    vga.vsync_out       = vsync_q;
    vga.frame_start_out = frame_start_q;
  end

endmodule
